// File: rtl/nubus_cpu_bridge.sv
// Processor-side request bridge for the NuBus controller CPU port.
// Posts writes through a small FIFO, holds reads behind them and re-issues try-again transactions.
module nubus_cpu_bridge #(
    parameter int DEPTH        = 4,
    parameter int RETRY_MAX    = 3,
    parameter int TRYAGAIN_BIT = 1
) (
    input  logic                       nub_clkn,
    input  logic                       nub_resetn,
    input  logic                       pcpu_valid,
    input  logic [31:0]                pcpu_addr,
    input  logic [31:0]                pcpu_wdata,
    input  logic [3:0]                 pcpu_wstrb,
    output logic                       pcpu_ready,
    output logic [31:0]                pcpu_rdata,
    output logic                       pcpu_error,
    output logic                       nbc_valid,
    output logic [31:0]                nbc_addr,
    output logic [31:0]                nbc_wdata,
    output logic [3:0]                 nbc_write,
    input  logic                       nbc_ready,
    input  logic [31:0]                nbc_rdata,
    input  logic [3:0]                 nbc_errors,
    output logic                       nbc_eclr,
    output logic                       post_err,
    input  logic                       post_err_clr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int RC_W  = $clog2(RETRY_MAX + 2);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [RC_W-1:0]  RETRY_LIM = RC_W'(RETRY_MAX);
    localparam logic [3:0]       TRY_MASK  = 4'(1 << TRYAGAIN_BIT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLEAR, GAP, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [67:0]      fifo_mem [DEPTH];
    logic [67:0]      head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             fifo_empty;
    logic             fifo_full;
    logic             req_block;
    logic             wr_ack;
    logic [31:0]      iss_addr;
    logic [31:0]      iss_wdata;
    logic [3:0]       iss_strb;
    logic [RC_W-1:0]  retry_cnt;
    logic             fatal;
    logic [31:0]      rdata_q;
    logic             is_read;
    logic             rd_inflight;
    logic             push;
    logic             pop;
    logic             rd_latch;
    logic             retry_inc;
    logic             go_fatal;
    logic             rd_ok;
    logic             set_perr;

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == FULL_LVL);
    assign head        = fifo_mem[rd_ptr];
    assign is_read     = (iss_strb == 4'b0);
    assign rd_inflight = (state != IDLE) && is_read;
    assign push        = pcpu_valid && (pcpu_wstrb != 4'b0) && !fifo_full
                         && !rd_inflight && !req_block;

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        rd_latch  = 1'b0;
        retry_inc = 1'b0;
        go_fatal  = 1'b0;
        rd_ok     = 1'b0;
        set_perr  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end else if (pcpu_valid && (pcpu_wstrb == 4'b0) && !req_block) begin
                    rd_latch = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (nbc_ready) begin
                    if (nbc_errors == 4'b0) begin
                        rd_ok    = is_read;
                        state_nx = is_read ? RESP : IDLE;
                    end else if ((nbc_errors == TRY_MASK) && (retry_cnt < RETRY_LIM)) begin
                        retry_inc = 1'b1;
                        state_nx  = CLEAR;
                    end else begin
                        go_fatal = 1'b1;
                        state_nx = CLEAR;
                    end
                end
            end
            CLEAR: begin
                if (!fatal) begin
                    state_nx = GAP;
                end else if (is_read) begin
                    state_nx = RESP;
                end else begin
                    set_perr = 1'b1;
                    state_nx = IDLE;
                end
            end
            GAP:     state_nx = WAIT;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(negedge nub_clkn) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pcpu_addr, pcpu_wdata, pcpu_wstrb};
        end
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // A request that has been acknowledged must drop valid once before another can be taken.
    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            req_block <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            wr_ack <= push;
            if (push || ((state == RESP) && pcpu_valid)) begin
                req_block <= 1'b1;
            end else if (!pcpu_valid) begin
                req_block <= 1'b0;
            end
        end
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_strb  <= '0;
            retry_cnt <= '0;
            fatal     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (pop) begin
                {iss_addr, iss_wdata, iss_strb} <= head;
                retry_cnt <= '0;
                fatal     <= 1'b0;
            end else if (rd_latch) begin
                iss_addr  <= pcpu_addr;
                iss_wdata <= pcpu_wdata;
                iss_strb  <= 4'b0;
                retry_cnt <= '0;
                fatal     <= 1'b0;
            end
            if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (go_fatal) begin
                fatal <= 1'b1;
            end
            if (rd_ok) begin
                rdata_q <= nbc_rdata;
            end
        end
    end

    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            post_err <= 1'b0;
        end else if (set_perr) begin
            post_err <= 1'b1;
        end else if (post_err_clr) begin
            post_err <= 1'b0;
        end
    end

    assign nbc_valid  = (state == WAIT);
    assign nbc_eclr   = (state == CLEAR);
    assign nbc_addr   = iss_addr;
    assign nbc_wdata  = iss_wdata;
    assign nbc_write  = iss_strb;
    assign pcpu_ready = wr_ack || (state == RESP);
    assign pcpu_error = (state == RESP) && fatal;
    assign pcpu_rdata = ((state == RESP) && !fatal) ? rdata_q : 32'h0;
    assign fifo_level = level;
    assign busy       = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_nubus_cpu_bridge.sv
// Directed testbench for nubus_cpu_bridge with a scripted NuBus controller responder.
`timescale 1ns/1ps
module tb_nubus_cpu_bridge;

    logic        nub_clkn = 1'b1;
    logic        nub_resetn = 1'b0;
    logic        pcpu_valid = 1'b0;
    logic [31:0] pcpu_addr = '0;
    logic [31:0] pcpu_wdata = '0;
    logic [3:0]  pcpu_wstrb = '0;
    logic        pcpu_ready;
    logic [31:0] pcpu_rdata;
    logic        pcpu_error;
    logic        nbc_valid;
    logic [31:0] nbc_addr;
    logic [31:0] nbc_wdata;
    logic [3:0]  nbc_write;
    logic        nbc_ready = 1'b0;
    logic [31:0] nbc_rdata = '0;
    logic [3:0]  nbc_errors = '0;
    logic        nbc_eclr;
    logic        post_err;
    logic        post_err_clr = 1'b0;
    logic [2:0]  fifo_level;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    bit          ctrl_en = 1'b0;
    int          ctrl_lat = 1;
    int          wait_cnt = 0;
    logic [31:0] ctrl_rdata = '0;
    logic [3:0]  default_err = '0;
    logic [3:0]  err_q[$];
    time         last_rdy_time = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_write[$];
    int          issue_cnt = 0;
    int          eclr_cnt = 0;
    logic        prev_valid = 1'b0;

    nubus_cpu_bridge #(.DEPTH(4), .RETRY_MAX(3), .TRYAGAIN_BIT(1)) dut (
        .nub_clkn     (nub_clkn),
        .nub_resetn   (nub_resetn),
        .pcpu_valid   (pcpu_valid),
        .pcpu_addr    (pcpu_addr),
        .pcpu_wdata   (pcpu_wdata),
        .pcpu_wstrb   (pcpu_wstrb),
        .pcpu_ready   (pcpu_ready),
        .pcpu_rdata   (pcpu_rdata),
        .pcpu_error   (pcpu_error),
        .nbc_valid    (nbc_valid),
        .nbc_addr     (nbc_addr),
        .nbc_wdata    (nbc_wdata),
        .nbc_write    (nbc_write),
        .nbc_ready    (nbc_ready),
        .nbc_rdata    (nbc_rdata),
        .nbc_errors   (nbc_errors),
        .nbc_eclr     (nbc_eclr),
        .post_err     (post_err),
        .post_err_clr (post_err_clr),
        .fifo_level   (fifo_level),
        .busy         (busy)
    );

    initial forever #5 nub_clkn = ~nub_clkn;

    // Controller model: answers after ctrl_lat cycles of valid, errors taken from the script queue.
    initial forever begin
        @(posedge nub_clkn);
        if (nbc_ready) begin
            nbc_ready  = 1'b0;
            nbc_errors = 4'b0;
            nbc_rdata  = 32'h0;
            wait_cnt   = 0;
        end else if (ctrl_en && nbc_valid) begin
            wait_cnt++;
            if (wait_cnt >= ctrl_lat) begin
                nbc_ready     = 1'b1;
                nbc_rdata     = ctrl_rdata;
                nbc_errors    = (err_q.size() > 0) ? err_q.pop_front() : default_err;
                last_rdy_time = $time;
                wait_cnt      = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial forever begin
        @(posedge nub_clkn);
        if (nbc_valid && !prev_valid) begin
            log_addr.push_back(nbc_addr);
            log_data.push_back(nbc_wdata);
            log_write.push_back(nbc_write);
            issue_cnt++;
        end
        if (nbc_eclr) eclr_cnt++;
        prev_valid = nbc_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int cycles);
        cycles     = -1;
        pcpu_valid = 1'b1;
        pcpu_addr  = a;
        pcpu_wdata = d;
        pcpu_wstrb = s;
        for (int i = 1; i <= 100; i++) begin
            @(posedge nub_clkn);
            if (pcpu_ready) begin
                cycles = i;
                break;
            end
        end
        pcpu_valid = 1'b0;
        pcpu_wstrb = 4'b0;
        @(posedge nub_clkn);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                            output int cycles, output time t);
        cycles     = -1;
        d          = 32'hX;
        e          = 1'bX;
        t          = 0;
        pcpu_valid = 1'b1;
        pcpu_addr  = a;
        pcpu_wdata = 32'h0;
        pcpu_wstrb = 4'b0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge nub_clkn);
            if (pcpu_ready) begin
                cycles = i;
                d      = pcpu_rdata;
                e      = pcpu_error;
                t      = $time;
                break;
            end
        end
        pcpu_valid = 1'b0;
        @(posedge nub_clkn);
    endtask

    task automatic test_reset();
        nub_resetn = 1'b0;
        repeat (3) @(posedge nub_clkn);
        n_checks++;
        if ({pcpu_ready, pcpu_error, nbc_valid, nbc_eclr, post_err, busy} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {pcpu_ready, pcpu_error, nbc_valid, nbc_eclr, post_err, busy});
        end
        n_checks++;
        if ({pcpu_rdata, nbc_addr, nbc_wdata, nbc_write} !== 100'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected all zero",
                     pcpu_rdata, nbc_addr, nbc_wdata, nbc_write);
        end
        n_checks++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
        end
        nub_resetn = 1'b1;
        repeat (2) @(posedge nub_clkn);
        n_checks++;
        if ({busy, nbc_valid, pcpu_ready} !== 3'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release_idle: got %b expected 000", {busy, nbc_valid, pcpu_ready});
        end
    endtask

    task automatic test_write_burst();
        int          cyc;
        int          base;
        bit          saw_ready;
        bit          got;
        logic [31:0] exp_a [6];
        logic [31:0] exp_d [6];
        ctrl_en  = 1'b0;
        ctrl_lat = 1;
        base     = log_addr.size();
        exp_a[0] = 32'hF000_0000;
        exp_d[0] = 32'hAAAA_0000;
        for (int n = 0; n < 5; n++) begin
            exp_a[n+1] = 32'hF100_0000 + 32'(4 * n);
            exp_d[n+1] = 32'(n);
        end

        cpu_write(exp_a[0], exp_d[0], 4'hF, cyc);
        n_checks++;
        if (cyc != 1) begin
            n_fail++;
            $display("[TB] FAIL lead_write_ack: got %0d cycles expected 1", cyc);
        end
        n_checks++;
        if (nbc_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL issue_not_early: got nbc_valid=%b expected 0", nbc_valid);
        end
        @(posedge nub_clkn);
        n_checks++;
        if ({nbc_valid, nbc_addr, nbc_write} !== {1'b1, 32'hF000_0000, 4'hF}) begin
            n_fail++;
            $display("[TB] FAIL issue_latency: got valid=%b addr=%h write=%h expected 1 F0000000 f",
                     nbc_valid, nbc_addr, nbc_write);
        end

        for (int n = 0; n < 4; n++) begin
            cpu_write(exp_a[n+1], exp_d[n+1], 4'hF, cyc);
            n_checks++;
            if (cyc != 1) begin
                n_fail++;
                $display("[TB] FAIL burst_ack_%0d: got %0d cycles expected 1", n, cyc);
            end
        end
        n_checks++;
        if (fifo_level !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL burst_level: got %0d expected 4", fifo_level);
        end

        pcpu_valid = 1'b1;
        pcpu_addr  = exp_a[5];
        pcpu_wdata = exp_d[5];
        pcpu_wstrb = 4'hF;
        saw_ready  = 1'b0;
        repeat (6) begin
            @(posedge nub_clkn);
            if (pcpu_ready) saw_ready = 1'b1;
        end
        n_checks++;
        if (saw_ready || fifo_level !== 3'd4) begin
            n_fail++;
            $display("[TB] FAIL full_stall: got ready=%b level=%0d expected 0 and 4", saw_ready, fifo_level);
        end
        ctrl_en = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge nub_clkn);
            if (pcpu_ready) begin
                got = 1'b1;
                break;
            end
        end
        pcpu_valid = 1'b0;
        pcpu_wstrb = 4'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL fifth_write_accept: got no ready expected ready after pop");
        end
        @(posedge nub_clkn);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(posedge nub_clkn);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL burst_drain: got busy=%b expected 0", busy);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (base + i >= log_addr.size()) begin
                n_fail++;
                $display("[TB] FAIL burst_order_%0d: got no issue expected addr %h", i, exp_a[i]);
            end else if ({log_addr[base+i], log_data[base+i], log_write[base+i]} !==
                         {exp_a[i], exp_d[i], 4'hF}) begin
                n_fail++;
                $display("[TB] FAIL burst_order_%0d: got %h/%h/%h expected %h/%h/f", i,
                         log_addr[base+i], log_data[base+i], log_write[base+i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_read_after_writes();
        int          cyc;
        int          base;
        logic [31:0] d;
        logic        e;
        time         t;
        logic [31:0] exp_a [3];
        logic [3:0]  exp_w [3];
        ctrl_en    = 1'b1;
        ctrl_lat   = 3;
        ctrl_rdata = 32'hDEAD_BEEF;
        base       = log_addr.size();
        exp_a[0] = 32'hF100_0020; exp_w[0] = 4'hF;
        exp_a[1] = 32'hF100_0024; exp_w[1] = 4'h3;
        exp_a[2] = 32'hF100_0000; exp_w[2] = 4'h0;
        cpu_write(exp_a[0], 32'h1111_1111, exp_w[0], cyc);
        cpu_write(exp_a[1], 32'h2222_2222, exp_w[1], cyc);
        cpu_read(exp_a[2], d, e, cyc, t);
        n_checks++;
        if (cyc < 0 || d !== 32'hDEAD_BEEF || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_data: got cyc=%0d rdata=%h err=%b expected DEADBEEF 0", cyc, d, e);
        end
        n_checks++;
        if (t - last_rdy_time != 10) begin
            n_fail++;
            $display("[TB] FAIL read_latency: got %0t expected 10 after nbc_ready", t - last_rdy_time);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (base + i >= log_addr.size()) begin
                n_fail++;
                $display("[TB] FAIL rd_order_%0d: got no issue expected addr %h", i, exp_a[i]);
            end else if ({log_addr[base+i], log_write[base+i]} !== {exp_a[i], exp_w[i]}) begin
                n_fail++;
                $display("[TB] FAIL rd_order_%0d: got %h/%h expected %h/%h", i,
                         log_addr[base+i], log_write[base+i], exp_a[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_tryagain();
        int          cyc;
        int          i0;
        int          e0;
        int          base;
        bit          addr_ok;
        logic [31:0] d;
        logic        e;
        time         t;
        ctrl_lat   = 1;
        ctrl_rdata = 32'h1234_5678;
        err_q.push_back(4'b0010);
        err_q.push_back(4'b0010);
        i0   = issue_cnt;
        e0   = eclr_cnt;
        base = log_addr.size();
        cpu_read(32'hF200_0000, d, e, cyc, t);
        n_checks++;
        if (cyc < 0 || d !== 32'h1234_5678 || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tryagain_data: got cyc=%0d rdata=%h err=%b expected 12345678 0", cyc, d, e);
        end
        n_checks++;
        if (issue_cnt - i0 != 3 || eclr_cnt - e0 != 2) begin
            n_fail++;
            $display("[TB] FAIL tryagain_counts: got issues=%0d eclr=%0d expected 3 2",
                     issue_cnt - i0, eclr_cnt - e0);
        end
        addr_ok = (log_addr.size() >= base + 3);
        for (int i = 0; i < 3; i++) begin
            if (addr_ok && {log_addr[base+i], log_write[base+i]} !== {32'hF200_0000, 4'h0})
                addr_ok = 1'b0;
        end
        n_checks++;
        if (!addr_ok) begin
            n_fail++;
            $display("[TB] FAIL tryagain_reissue_fields: got mismatched re-issue expected F2000000 read x3");
        end
    endtask

    task automatic test_retry_exhaust();
        int          cyc;
        int          i0;
        int          e0;
        logic [31:0] d;
        logic        e;
        time         t;
        ctrl_lat    = 1;
        ctrl_rdata  = 32'hCAFE_F00D;
        default_err = 4'b0010;
        i0 = issue_cnt;
        e0 = eclr_cnt;
        cpu_read(32'hF200_0004, d, e, cyc, t);
        default_err = 4'b0;
        n_checks++;
        if (cyc < 0 || d !== 32'h0 || e !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL exhaust_resp: got cyc=%0d rdata=%h err=%b expected 0 1", cyc, d, e);
        end
        n_checks++;
        if (issue_cnt - i0 != 4 || eclr_cnt - e0 != 4) begin
            n_fail++;
            $display("[TB] FAIL exhaust_counts: got issues=%0d eclr=%0d expected 4 4",
                     issue_cnt - i0, eclr_cnt - e0);
        end
    endtask

    task automatic test_fatal_write();
        int cyc;
        int i0;
        int e0;
        int base;
        bit seen;
        ctrl_lat = 3;
        err_q.push_back(4'b0001);
        i0   = issue_cnt;
        e0   = eclr_cnt;
        base = log_addr.size();
        cpu_write(32'hF300_0000, 32'h0000_0011, 4'hF, cyc);
        cpu_write(32'hF300_0004, 32'h0000_0022, 4'hF, cyc);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge nub_clkn);
            if (nbc_eclr) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL fatal_eclr: got no eclr pulse expected one");
        end
        post_err_clr = 1'b1;
        @(posedge nub_clkn);
        post_err_clr = 1'b0;
        n_checks++;
        if (post_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL perr_set_wins: got %b expected 1", post_err);
        end
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(posedge nub_clkn);
        end
        n_checks++;
        if (post_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL perr_sticky: got post_err=%b busy=%b expected 1 0", post_err, busy);
        end
        n_checks++;
        if (issue_cnt - i0 != 2 || eclr_cnt - e0 != 1 || log_addr.size() < base + 2) begin
            n_fail++;
            $display("[TB] FAIL fatal_counts: got issues=%0d eclr=%0d expected 2 1",
                     issue_cnt - i0, eclr_cnt - e0);
        end else if ({log_addr[base+1], log_data[base+1]} !== {32'hF300_0004, 32'h0000_0022}) begin
            n_fail++;
            $display("[TB] FAIL fatal_next_write: got %h/%h expected F3000004/00000022",
                     log_addr[base+1], log_data[base+1]);
        end
        post_err_clr = 1'b1;
        @(posedge nub_clkn);
        post_err_clr = 1'b0;
        n_checks++;
        if (post_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL perr_clear: got %b expected 0", post_err);
        end
    endtask

    task automatic test_reset_midflight();
        int cyc;
        int i0;
        ctrl_en  = 1'b0;
        ctrl_lat = 1;
        for (int n = 0; n < 4; n++) begin
            cpu_write(32'hF400_0000 + 32'(4 * n), 32'(n + 16), 4'hF, cyc);
        end
        n_checks++;
        if (fifo_level !== 3'd3 || nbc_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_setup: got level=%0d valid=%b expected 3 1", fifo_level, nbc_valid);
        end
        i0 = issue_cnt;
        #2;
        nub_resetn = 1'b0;
        #1;
        n_checks++;
        if (nbc_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_valid: got %b expected 0", nbc_valid);
        end
        n_checks++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_level: got %0d expected 0", fifo_level);
        end
        n_checks++;
        if (busy !== 1'b0 || nbc_addr !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_busy: got busy=%b addr=%h expected 0 0", busy, nbc_addr);
        end
        @(posedge nub_clkn);
        @(posedge nub_clkn);
        nub_resetn = 1'b1;
        ctrl_en    = 1'b1;
        repeat (10) @(posedge nub_clkn);
        n_checks++;
        if (issue_cnt != i0 || busy !== 1'b0 || nbc_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_no_issue: got issues=%0d busy=%b valid=%b expected %0d 0 0",
                     issue_cnt, busy, nbc_valid, i0);
        end
    endtask

    initial begin
        $display("[TB] starting nubus_cpu_bridge bench");
        test_reset();
        test_write_burst();
        test_read_after_writes();
        test_tryagain();
        test_retry_exhaust();
        test_fatal_write();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
